regfile_sync: RTL and testbench

- Architectural general-purpose register file: 32 x 32-bit, one write port and two read ports.
- The write port is the far end of the execute-result path. The EX stage's write address, write enable and write data travel through EX/MEM and MEM/WB and land here.
- Read ports feed the ID stage operands, which become the EX stage's reg1/reg2 inputs one stage later.
- Reads are registered (1-cycle latency), with write-to-read bypass so no stale operand is ever returned.

---
 rtl/regfile_sync.sv | 116 +++++++++++
 tb/tb_regfile_sync.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sync.sv
// -----------------------------------------------------------------------------
// regfile_sync
//
// Architectural general-purpose register file: NREGS x DATA_W, one write port
// and two registered read ports. The write port is driven from MEM/WB; the
// read ports feed the ID-stage operands.
//
// Reads have one cycle of latency. When a read and a write target the same
// register at the same edge, the read returns the data being written, so the
// ID stage never sees a stale operand. With ZERO_R0 set, register 0 always
// reads as zero and ignores writes.
//
// Ports:
//   clk     in   1       clock, all state updates on the rising edge
//   rst     in   1       asynchronous reset, active low (0 = in reset)
//   we      in   1       write enable
//   waddr   in   ADDR_W  write register address
//   wdata   in   DATA_W  write data
//   re1     in   1       read enable, port 1 (0 = rdata1 holds)
//   raddr1  in   ADDR_W  read address, port 1
//   rdata1  out  DATA_W  registered read data, port 1
//   re2     in   1       read enable, port 2 (0 = rdata2 holds)
//   raddr2  in   ADDR_W  read address, port 2
//   rdata2  out  DATA_W  registered read data, port 2
//
// NREGS must equal 2**ADDR_W so every address maps onto a real entry.
// -----------------------------------------------------------------------------
module regfile_sync #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NREGS   = 32,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NPORTS = 2;

    // Register storage and per-entry write select.
    logic [DATA_W-1:0] mem_q [NREGS];
    logic [NREGS-1:0]  wr_sel;

    // Read ports gathered into arrays so both ports share one generate body.
    logic              re_v    [NPORTS];
    logic [ADDR_W-1:0] raddr_v [NPORTS];
    logic [DATA_W-1:0] rdata_d [NPORTS];
    logic [DATA_W-1:0] rdata_q [NPORTS];

    assign re_v[0]    = re1;
    assign re_v[1]    = re2;
    assign raddr_v[0] = raddr1;
    assign raddr_v[1] = raddr2;
    assign rdata1     = rdata_q[0];
    assign rdata2     = rdata_q[1];

    // -------------------------------------------------------------------------
    // Storage: each entry is its own flop bank, loaded only when it is the
    // write target. Entry 0 has no write path when ZERO_R0 is set, so it stays
    // at its reset value of zero.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
            if ((ZERO_R0 != 0) && (gi == 0)) begin : g_hardwired
                assign wr_sel[gi] = 1'b0;
            end else begin : g_writable
                assign wr_sel[gi] = we && (waddr == ADDR_W'(gi));
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_q[gi] <= '0;
                end else if (wr_sel[gi]) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Read ports. Priority, lowest to highest: stored value, same-edge write
    // bypass, hardwired zero. The zero override sits last so an attempted
    // write to r0 can never leak through the bypass.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rport
            always_comb begin
                rdata_d[gi] = mem_q[raddr_v[gi]];
                if (we && (waddr == raddr_v[gi])) begin
                    rdata_d[gi] = wdata;
                end
                if ((ZERO_R0 != 0) && (raddr_v[gi] == '0)) begin
                    rdata_d[gi] = '0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_q[gi] <= '0;
                end else if (re_v[gi]) begin
                    rdata_q[gi] <= rdata_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sync.sv
// -----------------------------------------------------------------------------
// tb_regfile_sync
//
// Directed scenarios followed by randomized traffic. A reference model holds
// the architectural register contents and the value each read port should be
// showing; a compare process checks both read ports against it on every
// falling clock edge. Directed scenarios also check literal values.
// -----------------------------------------------------------------------------
module tb_regfile_sync;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              re1 = 1'b0;
    logic [ADDR_W-1:0] raddr1 = '0;
    logic [DATA_W-1:0] rdata1;
    logic              re2 = 1'b0;
    logic [ADDR_W-1:0] raddr2 = '0;
    logic [DATA_W-1:0] rdata2;

    int checks = 0;
    int errors = 0;

    regfile_sync #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .ZERO_R0(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model. Architecturally a write-first register file is
    // "commit the write, then read"; r0 is never committed, so it reads 0.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ref_mem [NREGS];
    logic [DATA_W-1:0] exp1 = '0;
    logic [DATA_W-1:0] exp2 = '0;

    initial begin
        for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
    end

    always @(negedge rst) begin
        for (int i = 0; i < NREGS; i++) ref_mem[i] = '0;
        exp1 = '0;
        exp2 = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (we && waddr != 0) ref_mem[waddr] = wdata;
            if (re1) exp1 = ref_mem[raddr1];
            if (re2) exp2 = ref_mem[raddr2];
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Continuous model comparison, away from the active edge.
    always @(negedge clk) begin
        chk("model_rdata1", rdata1, exp1);
        chk("model_rdata2", rdata2, exp2);
    end

    // Advance to 2 time units past the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        chk(name, act, exp);
        $display("txn %-16s rdata=%h expect=%h", name, act, exp);
    endtask

    initial begin
        logic [DATA_W-1:0] v;

        // ---------------- reset with write attempts ----------------
        #1 rst = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd3;
        repeat (3) begin
            cycle();
            wdata = ~wdata;
        end
        lit("rst_hold_rd1", rdata1, 32'h0);
        rst = 1'b1;
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd3;
        re2 = 1'b1; raddr2 = 5'd31;
        cycle();
        lit("rst_r3", rdata1, 32'h0);
        lit("rst_r31", rdata2, 32'h0);

        // ---------------- write then read, then hold ----------------
        re1 = 1'b0; re2 = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        cycle();
        we = 1'b0; re1 = 1'b1; raddr1 = 5'd5;
        cycle();
        lit("wr_rd_r5", rdata1, 32'h1234_5678);
        re1 = 1'b0; raddr1 = 5'd6;
        cycle();
        lit("hold_rd1", rdata1, 32'h1234_5678);

        // ---------------- same-cycle bypass ----------------
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0011;
        cycle();
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        cycle();
        lit("bypass_rd1", rdata1, 32'hDEAD_BEEF);
        lit("bypass_rd2", rdata2, 32'hDEAD_BEEF);

        // ---------------- back-to-back writes, last wins ----------------
        we = 1'b1; waddr = 5'd8; wdata = 32'h0000_0001; re1 = 1'b0; re2 = 1'b0;
        cycle();
        wdata = 32'h0000_0002; re1 = 1'b1; raddr1 = 5'd8;
        cycle();
        lit("b2b_bypass", rdata1, 32'h0000_0002);
        we = 1'b0;
        cycle();
        lit("b2b_stored", rdata1, 32'h0000_0002);

        // ---------------- register zero ----------------
        we = 1'b1; waddr = 5'd0; wdata = 32'hAAAA_AAAA;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd1;
        cycle();
        lit("r0_same_cycle", rdata1, 32'h0);
        lit("r1_unaffected", rdata2, 32'h0);
        we = 1'b0;
        cycle();
        lit("r0_next_cycle", rdata1, 32'h0);

        // ---------------- async reset mid-operation ----------------
        re1 = 1'b0; re2 = 1'b0;
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_00C3;
        cycle();
        we = 1'b0; re2 = 1'b1; raddr2 = 5'd9;
        cycle();
        lit("r9_before_rst", rdata2, 32'h0000_00C3);
        #1 rst = 1'b0;
        #1 lit("rst_immediate", rdata2, 32'h0);
        #4 rst = 1'b1;
        cycle();
        lit("r9_after_rst", rdata2, 32'h0);

        // ---------------- sweep ----------------
        re1 = 1'b0; re2 = 1'b0;
        for (int n = 1; n < NREGS; n++) begin
            we = 1'b1; waddr = ADDR_W'(n); wdata = DATA_W'(n) * 32'h0101_0101;
            cycle();
        end
        we = 1'b0; re1 = 1'b1; re2 = 1'b1;
        for (int n = 1; n < NREGS; n++) begin
            raddr1 = ADDR_W'(n);
            raddr2 = ADDR_W'(32 - n);
            cycle();
            v = DATA_W'(n) * 32'h0101_0101;
            lit($sformatf("sweep_p1_r%0d", n), rdata1, v);
            v = DATA_W'(32 - n) * 32'h0101_0101;
            lit($sformatf("sweep_p2_r%0d", 32 - n), rdata2, v);
        end

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            we     = ($urandom_range(0, 3) != 0);
            waddr  = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3))
                                                 : ADDR_W'($urandom);
            wdata  = $urandom;
            re1    = ($urandom_range(0, 4) != 0);
            re2    = ($urandom_range(0, 4) != 0);
            raddr1 = ($urandom_range(0, 1) != 0) ? ADDR_W'($urandom_range(0, 3))
                                                 : ADDR_W'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? raddr1 : ADDR_W'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst = 1'b0;
                #3 rst = 1'b1;
            end
            cycle();
        end

        we = 1'b0; re1 = 1'b0; re2 = 1'b0;
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
